mult_div_sequencer: RTL and testbench

Multi-cycle sequencer for the MULT/DIV operations that the ALU control decode emits (operation codes 12 and 13). It accepts one signed 32-bit multiply or divide per request, iterates one bit per cycle, and writes the results into architectural HI/LO registers. It raises a stall to the pipeline while an operation is in flight and pulses done on completion. It sits beside the single-cycle ALU in the EX stage.

---
 rtl/mult_div_sequencer_if.sv | 26 ++
 rtl/mult_div_sequencer.sv | 156 +++++++++++++++
 tb/tb_mult_div_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_sequencer_if.sv
// Request/result bundle between the EX-stage issue logic and the multi-cycle MULT/DIV sequencer.
// The master drives the request; the slave returns HI/LO, status and the pipeline stall.
interface mult_div_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
);
    logic             start;
    logic [OP_W-1:0]  alu_operation;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, alu_operation, rs_val, rt_val,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, alu_operation, rs_val, rt_val,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Bit-serial signed MULT/DIV sequencer writing architectural HI/LO.
// Works on operand magnitudes and fixes up signs in a single cycle at the end.
module mult_div_sequencer #(
    parameter int unsigned     WIDTH   = 32,
    parameter int unsigned     OP_W    = 4,
    parameter logic [OP_W-1:0] OP_MULT = OP_W'(12),
    parameter logic [OP_W-1:0] OP_DIV  = OP_W'(13)
) (
    input  logic                clk,
    input  logic                rst,
    mult_div_sequencer_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               valid_op, is_div_req, accept, div_zero;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, rem_shift, rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div_req = (bus_io.alu_operation == OP_DIV);
    assign valid_op   = (bus_io.alu_operation == OP_MULT) || is_div_req;
    assign accept     = (state_q == StIdle) && bus_io.start && valid_op;
    assign div_zero   = is_div_req && (bus_io.rt_val == '0);
    assign rs_mag     = bus_io.rs_val[WIDTH-1] ? -bus_io.rs_val : bus_io.rs_val;
    assign rt_mag     = bus_io.rt_val[WIDTH-1] ? -bus_io.rt_val : bus_io.rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    // Divide: dividend bits shift out of acc[WIDTH-1:0] while quotient bits shift in.
    assign rem_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, mag_q});
    assign rem_sub   = rem_shift - {1'b0, mag_q};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = div_zero ? StDone : StCalc;
            StCalc:  if (cnt_q == CntW'(1)) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_io.busy  = (state_q == StCalc) || (state_q == StFix);
        bus_io.done  = (state_q == StDone);
        bus_io.stall = bus_io.busy || accept;
        bus_io.hi    = hi_q;
        bus_io.lo    = lo_q;
    end

    always_comb begin
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_div_d  = is_div_req;
                    neg_res_d = bus_io.rs_val[WIDTH-1] ^ bus_io.rt_val[WIDTH-1];
                    neg_rem_d = bus_io.rs_val[WIDTH-1];
                    cnt_d     = CntW'(WIDTH);
                    rem_d     = '0;
                    if (is_div_req) begin
                        acc_d = {{WIDTH{1'b0}}, rs_mag};
                        mag_d = rt_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, rt_mag};
                        mag_d = rs_mag;
                    end
                    if (div_zero) begin
                        hi_d = bus_io.rs_val;
                        lo_d = '1;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntW'(1);
                if (is_div_q) begin
                    rem_d = rem_ge ? rem_sub : rem_shift;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mag_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench: directed cases with literal results plus a randomized run,
// all compared every cycle against a latency/arithmetic reference model.
module tb_mult_div_sequencer;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = WIDTH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_div_sequencer_if #(.WIDTH(WIDTH), .OP_W(4)) bus ();

    mult_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_valid(input logic [3:0] op);
        return (op == 4'd12) || (op == 4'd13);
    endfunction

    // Signed reference result packed as {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd12) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference model: cycles left busy, done pulse, architectural HI/LO.
    int          m_cnt  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
            end
        end else if (bus.start && is_valid(bus.alu_operation)) begin
            if (bus.alu_operation == 4'd13 && bus.rt_val == 32'd0) begin
                m_done <= 1'b1;
                m_hi   <= bus.rs_val;
                m_lo   <= 32'hFFFF_FFFF;
            end else begin
                m_cnt  <= LAT;
                m_pend <= ref_result(bus.alu_operation, bus.rs_val, bus.rt_val);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("busy", bus.busy, 64'(m_cnt != 0));
            check("done", bus.done, 64'(m_done));
            check("stall", bus.stall,
                  64'((m_cnt != 0) || (!m_done && bus.start && is_valid(bus.alu_operation))));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    // exp_cyc: cycle (start cycle = 0) in which done is seen; 0 means the request is ignored.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [31:0] ehi, input logic [31:0] elo,
                         input string tag);
        int lat;
        @(posedge clk);
        #1;
        bus.start         = 1'b1;
        bus.alu_operation = op;
        bus.rs_val        = a;
        bus.rt_val        = b;
        #1;
        check({tag, "_stall"}, bus.stall, 64'(exp_cyc != 0));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        if (exp_cyc != 0) begin
            lat = 1;
            while (!bus.done && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({tag, "_cycles"}, 64'(lat), 64'(exp_cyc));
        end
        check({tag, "_hi"}, bus.hi, ehi);
        check({tag, "_lo"}, bus.lo, elo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start         = 1'b0;
        bus.alu_operation = 4'd0;
        bus.rs_val        = '0;
        bus.rt_val        = '0;
        #12;
        check("rst_busy", bus.busy, 64'd0);
        check("rst_done", bus.done, 64'd0);
        check("rst_stall", bus.stall, 64'd0);
        check("rst_hi", bus.hi, 64'd0);
        check("rst_lo", bus.lo, 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        issue(4'd12, 32'd7, -32'd3, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul_7_m3");
        issue(4'd13, -32'd7, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        issue(4'd13, 32'd7, -32'd2, 34, 32'd1, 32'hFFFF_FFFD, "div_7_m2");
        issue(4'd13, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, "div_by_0");
        issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, "div_ovf");

        fork
            issue(4'd12, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'd0, "mul_min");
            begin
                repeat (11) @(posedge clk);
                #2;
                bus.start         = 1'b1;
                bus.alu_operation = 4'd13;
                bus.rs_val        = 32'd99;
                bus.rt_val        = 32'd3;
                @(posedge clk);
                #2;
                bus.start = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("no_extra_done", bus.done, 64'd0);

        issue(4'd8, 32'd11, 32'd22, 0, 32'h4000_0000, 32'd0, "add_ignored");

        // Reset in the middle of a multiply.
        @(posedge clk);
        #1;
        bus.start         = 1'b1;
        bus.alu_operation = 4'd12;
        bus.rs_val        = 32'd7;
        bus.rt_val        = -32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 64'd0);
        check("mid_rst_stall", bus.stall, 64'd0);
        check("mid_rst_hi", bus.hi, 64'd0);
        check("mid_rst_lo", bus.lo, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(4'd13, 32'd100, 32'd7, 34, 32'd2, 32'd14, "div_100_7");

        // Randomized traffic, including start during busy and done.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.alu_operation = 4'd12;
                1:       bus.alu_operation = 4'd13;
                2:       bus.alu_operation = 4'd8;
                default: bus.alu_operation = 4'($urandom_range(0, 15));
            endcase
            bus.rs_val = pick();
            bus.rt_val = pick();
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
